// File: rtl/ro_meter_pkg.sv
// Shared types and default widths for the ring-oscillator frequency meter.
package ro_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEASURE,
    ST_DONE
  } ro_state_t;

  localparam int unsigned RO_CNT_W_DEF  = 16;
  localparam int unsigned RO_GATE_W_DEF = 16;

endpackage

// File: rtl/ro_meter_sync_edge.sv
// Oscillator input synchroniser and rising-edge detector.
// Optional 3-sample majority glitch filter under RO_METER_GLITCH_FILTER_EN.
module ro_meter_sync_edge (
  input  logic CLK,
  input  logic RN,
  input  logic OSC,
  output logic rise
);

  logic s1;
  logic s2;
  logic sp;
  logic lvl;

`ifdef RO_METER_GLITCH_FILTER_EN
  logic f1;
  logic f2;
  logic maj_q;

  // Majority is registered, so a clean edge reaches sp two cycles later than unfiltered.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      f1    <= 1'b0;
      f2    <= 1'b0;
      maj_q <= 1'b0;
    end else begin
      s1    <= OSC;
      s2    <= s1;
      f1    <= s2;
      f2    <= f1;
      maj_q <= (s2 & f1) | (s2 & f2) | (f1 & f2);
    end
  end

  assign lvl = maj_q;
`else
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= OSC;
      s2 <= s1;
    end
  end

  assign lvl = s2;
`endif

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) sp <= 1'b0;
    else     sp <= lvl;
  end

  assign rise = lvl & ~sp;

endmodule

// File: rtl/ro_freq_meter.sv
// Gated ring-oscillator edge counter with START/BUSY/DONE handshake.
// Build option: RO_METER_GLITCH_FILTER_EN enables the input majority filter.
module ro_freq_meter
  import ro_meter_pkg::*;
#(
  parameter int unsigned CNT_W  = RO_CNT_W_DEF,
  parameter int unsigned GATE_W = RO_GATE_W_DEF
) (
  input  logic              CLK,
  input  logic              RN,
  input  logic              START,
  input  logic [GATE_W-1:0] GATE,
  input  logic              OSC,
  output logic              BUSY,
  output logic              DONE,
  output logic [CNT_W-1:0]  COUNT,
  output logic              OVF
);

  ro_state_t         state, state_nxt;
  logic [GATE_W-1:0] gate_cnt, gate_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [CNT_W-1:0]  count_q, count_nxt;
  logic              ovf_q, ovf_nxt;
  logic              rise;

  ro_meter_sync_edge u_sync (
    .CLK  (CLK),
    .RN   (RN),
    .OSC  (OSC),
    .rise (rise)
  );

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state    <= ST_IDLE;
      gate_cnt <= '0;
      cnt      <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      gate_cnt <= gate_nxt;
      cnt      <= cnt_nxt;
      count_q  <= count_nxt;
      ovf_q    <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gate_nxt  = gate_cnt;
    cnt_nxt   = cnt;
    count_nxt = count_q;
    ovf_nxt   = ovf_q;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          state_nxt = ST_ARM;
          gate_nxt  = GATE;
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
        end
      end
      ST_ARM: begin
        if (gate_cnt == '0) begin
          state_nxt = ST_DONE;
          count_nxt = cnt;
        end else begin
          state_nxt = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        gate_nxt = gate_cnt - 1'b1;
        if (rise) begin
          if (cnt == '1) ovf_nxt = 1'b1;
          else           cnt_nxt = cnt + 1'b1;
        end
        // COUNT is captured on the way into DONE so it is valid in DONE's first cycle.
        if (gate_cnt == GATE_W'(1)) begin
          state_nxt = ST_DONE;
          count_nxt = cnt_nxt;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign BUSY  = (state == ST_ARM) || (state == ST_MEASURE);
  assign DONE  = (state == ST_DONE);
  assign COUNT = count_q;
  assign OVF   = ovf_q;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Directed/randomised bench for ro_freq_meter: one 16-bit and one 4-bit counter instance.
module tb_ro_freq_meter;

`ifdef RO_METER_GLITCH_FILTER_EN
  localparam int LAT_LO = 4;
  localparam int LAT_HI = 5;
  localparam int SAT_P  = 5;
`else
  localparam int LAT_LO = 2;
  localparam int LAT_HI = 3;
  localparam int SAT_P  = 4;
`endif

  logic        CLK = 1'b0;
  logic        RN;
  logic        START;
  logic [15:0] GATE;
  logic        OSC;

  logic        busy_a, done_a, ovf_a;
  logic [15:0] count_a;
  logic        busy_b, done_b, ovf_b;
  logic [3:0]  count_b;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int          cyc   = 0;
  int          osc_p = 0;
  int          osc_ph = 0;
  bit          glitch_en = 1'b0;
  bit          clean_prev = 1'b0;
  int          edges[$];

  always #5 CLK = ~CLK;

  ro_freq_meter #(.CNT_W(16), .GATE_W(16)) dut_a (
    .CLK(CLK), .RN(RN), .START(START), .GATE(GATE), .OSC(OSC),
    .BUSY(busy_a), .DONE(done_a), .COUNT(count_a), .OVF(ovf_a)
  );

  ro_freq_meter #(.CNT_W(4), .GATE_W(16)) dut_b (
    .CLK(CLK), .RN(RN), .START(START), .GATE(GATE), .OSC(OSC),
    .BUSY(busy_b), .DONE(done_b), .COUNT(count_b), .OVF(ovf_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input logic [31:0] obs, input int lo, input int hi);
    total++;
    assert ((obs >= lo) && (obs <= hi)) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Advance one cycle; inputs change 2 time units after the rising edge.
  task automatic tick();
    bit clean, glitch;
    @(posedge CLK);
    cyc++;
    #2;
    clean  = 1'b0;
    glitch = 1'b0;
    if (osc_p > 0) begin
      clean  = ((cyc + osc_ph) % osc_p) < (osc_p / 2);
      glitch = glitch_en && (((cyc + osc_ph) % osc_p) == 7);
    end
    if (clean && !clean_prev) edges.push_back(cyc);
    clean_prev = clean;
    OSC = clean | glitch;
  endtask

  // Edges certainly / possibly landing in MEASURE cycles t+2 .. t+1+g.
  task automatic model(input int t, input int g, output int lo, output int hi);
    bit any, all;
    int p;
    lo = 0;
    hi = 0;
    foreach (edges[i]) begin
      any = 1'b0;
      all = 1'b1;
      for (int l = LAT_LO; l <= LAT_HI; l++) begin
        p = edges[i] + l;
        if ((p >= t + 2) && (p <= t + 1 + g)) any = 1'b1;
        else all = 1'b0;
      end
      if (any) hi++;
      if (all) lo++;
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] cnt, input logic ovf,
                              input int maxv, input int lo, input int hi);
    check_rng({tag, "/count"}, cnt, (lo > maxv) ? maxv : lo, (hi > maxv) ? maxv : hi);
    if (lo > maxv)       check({tag, "/ovf"}, {31'd0, ovf}, 32'd1);
    else if (hi <= maxv) check({tag, "/ovf"}, {31'd0, ovf}, 32'd0);
  endtask

  // START issued in the current cycle; poke >= 0 re-pulses START during the window.
  task automatic run(input int g, input int poke, input string tag);
    int t, lo, hi;
    t = cyc;
    START = 1'b1;
    GATE = g[15:0];
    tick();
    START = 1'b0;
    GATE = 16'($urandom);
    check({tag, "/busy_arm"}, {31'd0, busy_a}, 32'd1);
    check({tag, "/done_arm"}, {31'd0, done_a}, 32'd0);
    check({tag, "/busy_arm_b"}, {31'd0, busy_b}, 32'd1);
    for (int i = 0; i < g; i++) begin
      if (i == poke) START = 1'b1;
      tick();
      START = 1'b0;
    end
    check({tag, "/busy_last"}, {31'd0, busy_a}, 32'd1);
    check({tag, "/done_last"}, {31'd0, done_a}, 32'd0);
    tick();
    check({tag, "/done"}, {31'd0, done_a}, 32'd1);
    check({tag, "/busy_done"}, {31'd0, busy_a}, 32'd0);
    check({tag, "/done_b"}, {31'd0, done_b}, 32'd1);
    model(t, g, lo, hi);
    check_result({tag, "/a"}, {16'd0, count_a}, ovf_a, 65535, lo, hi);
    check_result({tag, "/b"}, {28'd0, count_b}, ovf_b, 15, lo, hi);
  endtask

  initial begin
    RN = 1'b1;
    START = 1'b0;
    GATE = '0;
    OSC = 1'b0;
    #1 RN = 1'b0;
    #2;
    check("rst/busy", {31'd0, busy_a}, 32'd0);
    check("rst/done", {31'd0, done_a}, 32'd0);
    check("rst/count", {16'd0, count_a}, 32'd0);
    check("rst/ovf", {31'd0, ovf_a}, 32'd0);
    repeat (3) tick();
    RN = 1'b1;

    osc_p = 8; osc_ph = 0;
    repeat (8) tick();
    run(800, -1, "nominal");

    osc_p = SAT_P; osc_ph = 1;
    repeat (8) tick();
    run(200, -1, "sat");
    run(8, -1, "b2b_short");

    osc_p = 6; osc_ph = 2;
    repeat (8) tick();
    run(0, -1, "zero_gate");
    run(50, 10, "start_ignored");

    for (int r = 0; r < 6; r++) begin
      osc_p  = $urandom_range(13, 5);
      osc_ph = $urandom_range(osc_p - 1, 0);
      repeat (8 + $urandom_range(4, 0)) tick();
      run($urandom_range(300, 0), -1, "rand");
    end

`ifdef RO_METER_GLITCH_FILTER_EN
    osc_p = 10; osc_ph = 0; glitch_en = 1'b1;
    repeat (8) tick();
    run(1000, -1, "glitch");
    glitch_en = 1'b0;
`endif

    osc_p = 6; osc_ph = 0;
    repeat (8) tick();
    run(40, -1, "pre_rst");
    START = 1'b1;
    GATE = 16'd100;
    tick();
    START = 1'b0;
    repeat (20) tick();
    check("mid/busy", {31'd0, busy_a}, 32'd1);
    RN = 1'b0;
    #1;
    check("mid_rst/busy", {31'd0, busy_a}, 32'd0);
    check("mid_rst/done", {31'd0, done_a}, 32'd0);
    check("mid_rst/count", {16'd0, count_a}, 32'd0);
    check("mid_rst/ovf", {31'd0, ovf_a}, 32'd0);
    check("mid_rst/count_b", {28'd0, count_b}, 32'd0);
    tick();
    tick();
    RN = 1'b1;
    tick();
    check("post_rst/busy", {31'd0, busy_a}, 32'd0);
    check("post_rst/done", {31'd0, done_a}, 32'd0);
    repeat (8) tick();
    run(60, -1, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
